// File: rtl/hazard_controller.sv
// Hazard, forwarding and memory-wait sequencing for the five-stage pipeline.
// Optional macro HAZ_PERF_CNT_EN builds saturating stall/flush performance counters.
module hazard_controller #(
    parameter int AWL  = 6,
    parameter int DWL  = 32,
    parameter int TOUT = 16
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic [AWL-2:0] RsD,
    input  logic [AWL-2:0] RtD,
    input  logic [AWL-2:0] RsE,
    input  logic [AWL-2:0] RtE,
    input  logic [AWL-2:0] WriteRegE,
    input  logic [AWL-2:0] WriteRegM,
    input  logic [AWL-2:0] WriteRegW,
    input  logic           RFWEE,
    input  logic           RFWEM,
    input  logic           RFWEW,
    input  logic           MtoRFSelE,
    input  logic           MtoRFSelM,
    input  logic           BranchD,
    input  logic           JumpD,
    input  logic           PCSelD,
    input  logic           DMReqM,
    input  logic           DMAckM,
    output logic           StallF,
    output logic           StallD,
    output logic           StallE,
    output logic           StallM,
    output logic           FlushD,
    output logic           FlushE,
    output logic           ForwardAD,
    output logic           ForwardBD,
    output logic [1:0]     ForwardAE,
    output logic [1:0]     ForwardBE,
    output logic           MemErr,
    output logic [DWL-1:0] StallCnt,
    output logic [DWL-1:0] FlushCnt
);

    localparam int CW = (TOUT > 1) ? $clog2(TOUT) : 1;

    typedef enum logic [1:0] {RUN, MWAIT, MERR} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wcnt;
    logic            r_mem_err;
    logic            w_freeze;
    logic            w_lwstall;
    logic            w_brstall;
    logic            w_hazstall;

    // Register 0 is hardwired, so it never forwards and never stalls.
    function automatic logic f_match(input logic [AWL-2:0] a, input logic [AWL-2:0] w,
                                     input logic we);
        return we && (w != '0) && (a == w);
    endfunction

    always_comb begin
        ForwardAD = f_match(RsD, WriteRegM, RFWEM);
        ForwardBD = f_match(RtD, WriteRegM, RFWEM);
        ForwardAE = f_match(RsE, WriteRegM, RFWEM) ? 2'b10 :
                    f_match(RsE, WriteRegW, RFWEW) ? 2'b01 : 2'b00;
        ForwardBE = f_match(RtE, WriteRegM, RFWEM) ? 2'b10 :
                    f_match(RtE, WriteRegW, RFWEW) ? 2'b01 : 2'b00;
    end

    always_comb begin
        w_lwstall  = MtoRFSelE && RFWEE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
        w_brstall  = BranchD &&
                     (f_match(RsD, WriteRegE, RFWEE) || f_match(RtD, WriteRegE, RFWEE) ||
                      (MtoRFSelM && (f_match(RsD, WriteRegM, RFWEM) ||
                                     f_match(RtD, WriteRegM, RFWEM))));
        w_hazstall = w_lwstall || w_brstall;
    end

    // Freeze follows the ack combinationally so release happens in the ack cycle.
    always_comb begin
        w_next   = r_state;
        w_freeze = 1'b0;
        case (r_state)
            RUN: begin
                if (DMReqM && !DMAckM) begin
                    w_next   = MWAIT;
                    w_freeze = 1'b1;
                end
            end
            MWAIT: begin
                if (DMAckM) begin
                    w_next = RUN;
                end else begin
                    w_freeze = 1'b1;
                    if (r_wcnt == CW'(TOUT - 1)) begin
                        w_next = MERR;
                    end
                end
            end
            MERR: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (w_freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (w_hazstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end else if (PCSelD || JumpD) begin
            FlushD = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state   <= RUN;
            r_wcnt    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == MWAIT && w_next == MWAIT) begin
                r_wcnt <= r_wcnt + CW'(1);
            end else if (r_state != MERR) begin
                r_wcnt <= '0;
            end
            if (w_next == MERR) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign MemErr = r_mem_err;

`ifdef HAZ_PERF_CNT_EN
    logic [DWL-1:0] r_stall_cnt;
    logic [DWL-1:0] r_flush_cnt;

    // Hazard stalls hidden under a memory freeze are not counted.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazstall && !w_freeze && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + DWL'(1);
            end
            if ((FlushD || FlushE) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + DWL'(1);
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_controller;

    localparam int AWL  = 6;
    localparam int DWL  = 32;
    localparam int TOUT = 16;
    localparam int RW   = AWL - 1;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          CLK, CLR;
    logic [RW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic          RFWEE, RFWEM, RFWEW, MtoRFSelE, MtoRFSelM;
    logic          BranchD, JumpD, PCSelD, DMReqM, DMAckM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic          ForwardAD, ForwardBD, MemErr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [DWL-1:0] StallCnt, FlushCnt;

    hazard_controller #(.AWL(AWL), .DWL(DWL), .TOUT(TOUT)) dut (
        .CLK(CLK), .CLR(CLR),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RFWEE(RFWEE), .RFWEM(RFWEM), .RFWEW(RFWEW),
        .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM),
        .BranchD(BranchD), .JumpD(JumpD), .PCSelD(PCSelD),
        .DMReqM(DMReqM), .DMAckM(DMAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: a pending wait, how long it has lasted, the sticky error and counters.
    bit          m_waiting;
    int          m_waited;
    bit          m_err;
    longint      m_sc, m_fc;
    logic [5:0]  e_ctl;
    logic [5:0]  e_fwd;
    bit          e_hz, e_fz;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mt(input logic [RW-1:0] a, input logic [RW-1:0] w, input logic we);
        return we && (w != 0) && (a == w);
    endfunction

    function automatic logic [1:0] esel(input logic [RW-1:0] r);
        if (mt(r, WriteRegM, RFWEM)) return 2'b10;
        if (mt(r, WriteRegW, RFWEW)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit lw, br;
        e_fz = m_err || (!DMAckM && (DMReqM || m_waiting));
        lw   = MtoRFSelE && RFWEE && (RtE != 0) && (RtE == RsD || RtE == RtD);
        br   = BranchD && (mt(RsD, WriteRegE, RFWEE) || mt(RtD, WriteRegE, RFWEE) ||
               (MtoRFSelM && (mt(RsD, WriteRegM, RFWEM) || mt(RtD, WriteRegM, RFWEM))));
        e_hz = lw || br;
        if (e_fz)                 e_ctl = 6'b111100;
        else if (e_hz)            e_ctl = 6'b110001;
        else if (PCSelD || JumpD) e_ctl = 6'b000010;
        else                      e_ctl = 6'b000000;
        e_fwd = {mt(RsD, WriteRegM, RFWEM), mt(RtD, WriteRegM, RFWEM), esel(RsE), esel(RtE)};
    endtask

    task automatic model_update();
        model_eval();
        if (e_hz && !e_fz && m_sc < 64'hFFFF_FFFF) m_sc++;
        if ((e_ctl[1] || e_ctl[0]) && m_fc < 64'hFFFF_FFFF) m_fc++;
        if (!m_err) begin
            if (m_waiting) begin
                if (DMAckM) m_waiting = 0;
                else begin
                    m_waited++;
                    if (m_waited == TOUT) begin
                        m_err     = 1;
                        m_waiting = 0;
                    end
                end
            end else if (DMReqM && !DMAckM) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic clr_in();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RFWEE = 0; RFWEM = 0; RFWEW = 0; MtoRFSelE = 0; MtoRFSelM = 0;
        BranchD = 0; JumpD = 0; PCSelD = 0; DMReqM = 0; DMAckM = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic step();
        @(negedge CLK);
        model_eval();
        check_eq("ctl", {StallF, StallD, StallE, StallM, FlushD, FlushE}, e_ctl);
        check_eq("fwd", {ForwardAD, ForwardBD, ForwardAE, ForwardBE}, e_fwd);
        check_eq("memerr", MemErr, m_err);
        check_eq("stallcnt", StallCnt, PERF ? m_sc : 0);
        check_eq("flushcnt", FlushCnt, PERF ? m_fc : 0);
        tick();
    endtask

    function automatic logic [5:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE};
    endfunction

    initial begin
        CLR = 1'b0;
        clr_in();
        model_reset();
        #1 CLR = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("rst_ctl", ctl(), 6'b0);
        check_eq("rst_fwd", {ForwardAD, ForwardBD, ForwardAE, ForwardBE}, 6'b0);
        check_eq("rst_memerr", MemErr, 1'b0);
        check_eq("rst_cnt", {StallCnt, FlushCnt}, 64'd0);
        #1 CLR = 1'b0;

        // Execute forwarding priority and register 0 exclusion
        RsE = 3; WriteRegM = 3; RFWEM = 1; WriteRegW = 3; RFWEW = 1;
        #1 check_eq("fwdAE_M", ForwardAE, 2'b10);
        step();
        RFWEM = 0;
        #1 check_eq("fwdAE_W", ForwardAE, 2'b01);
        step();
        RsE = 0;
        #1 check_eq("fwdAE_r0", ForwardAE, 2'b00);
        step();

        // Load-use stall
        clr_in();
        MtoRFSelE = 1; RFWEE = 1; RtE = 5; RsD = 5;
        #1 check_eq("lw_ctl", ctl(), 6'b110001);
        step();
        MtoRFSelE = 0;
        #1 check_eq("lw_clear", ctl(), 6'b000000);
        step();
        check_eq("lw_scnt", StallCnt, PERF ? 64'd1 : 64'd0);
        check_eq("lw_fcnt", FlushCnt, PERF ? 64'd1 : 64'd0);

        // Branch compare stall, then forward from M and taken-branch flush
        clr_in();
        BranchD = 1; RsD = 7; WriteRegE = 7; RFWEE = 1;
        #1 check_eq("br_stall", ctl(), 6'b110001);
        step();
        WriteRegE = 0; RFWEE = 0; WriteRegM = 7; RFWEM = 1; MtoRFSelM = 0;
        #1 check_eq("br_nostall", ctl(), 6'b000000);
        check_eq("br_fwdAD", ForwardAD, 1'b1);
        PCSelD = 1;
        #1 check_eq("br_flushD", ctl(), 6'b000010);
        step();

        // Memory wait acknowledged after three cycles
        clr_in();
        DMReqM = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("mw_frz", ctl(), 6'b111100);
            step();
        end
        DMAckM = 1;
        #1 check_eq("mw_ack", ctl(), 6'b000000);
        step();
        clr_in();
        #1 check_eq("mw_run", ctl(), 6'b000000);
        check_eq("mw_memerr", MemErr, 1'b0);
        step();

        // Timeout: one RUN cycle then TOUT MWAIT cycles
        DMReqM = 1;
        for (int i = 0; i < TOUT; i++) step();
        check_eq("to_before", MemErr, 1'b0);
        step();
        check_eq("to_memerr", MemErr, 1'b1);
        DMReqM = 0;
        #1 check_eq("to_frz", ctl(), 6'b111100);
        step();
        @(negedge CLK);
        #1 CLR = 1'b1;
        #1;
        check_eq("clr_memerr", MemErr, 1'b0);
        check_eq("clr_ctl", ctl(), 6'b000000);
        model_reset();
        #1 CLR = 1'b0;
        tick();

        // Hazard and taken branch underneath a freeze
        clr_in();
        MtoRFSelE = 1; RFWEE = 1; RtE = 5; RsD = 5; PCSelD = 1; DMReqM = 1;
        #1 check_eq("sim_frz", ctl(), 6'b111100);
        step();
        DMAckM = 1;
        #1 check_eq("sim_ack", ctl(), 6'b110001);
        step();
        clr_in();
        step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            RsD = RW'($urandom_range(0, 3)); RtD = RW'($urandom_range(0, 3));
            RsE = RW'($urandom_range(0, 3)); RtE = RW'($urandom_range(0, 3));
            WriteRegE = RW'($urandom_range(0, 3));
            WriteRegM = RW'($urandom_range(0, 3));
            WriteRegW = RW'($urandom_range(0, 3));
            RFWEE = 1'($urandom); RFWEM = 1'($urandom); RFWEW = 1'($urandom);
            MtoRFSelE = 1'($urandom); MtoRFSelM = 1'($urandom);
            BranchD = 1'($urandom); JumpD = ($urandom_range(0, 3) == 0);
            PCSelD = ($urandom_range(0, 3) == 0);
            DMReqM = ($urandom_range(0, 3) == 0);
            DMAckM = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
